// File: rtl/peripheral_biu_pkg.sv
// ----------------------------------------------------------------------------
// peripheral_biu_pkg
// Shared types and constants for the BIU-side peripheral arbiters.
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - SIZE_W / TYPE_W / PROT_W : widths of the BIU size, burst type and
//     protection fields
// ----------------------------------------------------------------------------
package peripheral_biu_pkg;

    localparam int SIZE_W = 3;
    localparam int TYPE_W = 3;
    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/peripheral_mpram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// peripheral_mpram_rr_arbiter
// Purely combinational round-robin priority picker. The first index at or
// above ptr_i (wrapping modulo N) whose request is set and not masked off
// wins.
// Ports:
//   req_i       : request vector
//   ptr_i       : round-robin start index
//   mask_i      : eligibility mask (1 = may win)
//   grant_oh_o  : one-hot winner
//   grant_idx_o : binary winner index
//   valid_o     : a winner exists
// ----------------------------------------------------------------------------
module peripheral_mpram_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          valid_o
);

    logic [N-1:0]  elig;
    logic [IW-1:0] cand;

    assign elig = req_i & mask_i;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!valid_o && elig[cand]) begin
                valid_o     = 1'b1;
                grant_idx_o = cand;
                grant_oh_o  = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/peripheral_mpram_arbiter_tl.sv
// ----------------------------------------------------------------------------
// peripheral_mpram_arbiter_tl
// Round-robin arbiter sharing one TILELINK-style BIU slave port (the MPRAM
// peripheral) between CORES requesters.
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   req_*_i / req_*_o       : per-requester BIU ports, slice k of each
//                             packed bus belongs to requester k
//   biu_*_o / biu_*_i       : single slave-side BIU port
//   grant_o                 : index of the current or last owner
//
// Handshake: a requester holds req_stb_i and its attributes until it sees
// req_stb_ack_o; req_ack_o / req_err_o then pulse once when the slave
// completes. On the slave side biu_stb_o is held with stable attributes
// until biu_stb_ack_i; completion is biu_ack_i or biu_err_i afterwards
// (or in the same cycle as biu_stb_ack_i).
// ----------------------------------------------------------------------------
module peripheral_mpram_arbiter_tl
    import peripheral_biu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int PLEN  = 64,
    parameter int CORES = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [CORES-1:0]           req_stb_i,
    output logic [CORES-1:0]           req_stb_ack_o,
    input  logic [CORES*PLEN-1:0]      req_adri_i,
    input  logic [CORES*SIZE_W-1:0]    req_size_i,
    input  logic [CORES*TYPE_W-1:0]    req_type_i,
    input  logic [CORES*PROT_W-1:0]    req_prot_i,
    input  logic [CORES-1:0]           req_lock_i,
    input  logic [CORES-1:0]           req_we_i,
    input  logic [CORES*XLEN-1:0]      req_d_i,
    output logic [CORES*XLEN-1:0]      req_q_o,
    output logic [CORES-1:0]           req_ack_o,
    output logic [CORES-1:0]           req_err_o,

    output logic                       biu_stb_o,
    input  logic                       biu_stb_ack_i,
    output logic [PLEN-1:0]            biu_adri_o,
    output logic [SIZE_W-1:0]          biu_size_o,
    output logic [TYPE_W-1:0]          biu_type_o,
    output logic [PROT_W-1:0]          biu_prot_o,
    output logic                       biu_lock_o,
    output logic                       biu_we_o,
    output logic [XLEN-1:0]            biu_d_o,
    input  logic [XLEN-1:0]            biu_q_i,
    input  logic                       biu_ack_i,
    input  logic                       biu_err_i,

    output logic [$clog2(CORES)-1:0]   grant_o
);

    localparam int GW = $clog2(CORES);

    arb_state_e              state_q;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           lock_owner_q;
    logic                    lock_owner_valid_q;

    logic                    biu_stb_q;
    logic [PLEN-1:0]         biu_adri_q;
    logic [SIZE_W-1:0]       biu_size_q;
    logic [TYPE_W-1:0]       biu_type_q;
    logic [PROT_W-1:0]       biu_prot_q;
    logic                    biu_lock_q;
    logic                    biu_we_q;
    logic [XLEN-1:0]         biu_d_q;

    logic [CORES-1:0]        req_stb_ack_q;
    logic [CORES-1:0]        req_ack_q;
    logic [CORES-1:0]        req_err_q;
    logic [CORES*XLEN-1:0]   req_q_q;

    logic [CORES-1:0]        elig_mask;
    logic [CORES-1:0]        pick_oh;
    logic [GW-1:0]           pick_idx;
    logic                    pick_valid;
    logic [CORES-1:0]        grant_oh;
    logic                    complete;

    logic [PLEN-1:0]         sel_adri;
    logic [SIZE_W-1:0]       sel_size;
    logic [TYPE_W-1:0]       sel_type;
    logic [PROT_W-1:0]       sel_prot;
    logic                    sel_lock;
    logic                    sel_we;
    logic [XLEN-1:0]         sel_d;

    // A held lock restricts arbitration to its owner, even if that owner
    // is not strobing (the arbiter then simply waits).
    assign elig_mask = lock_owner_valid_q ? (CORES'(1) << lock_owner_q) : '1;
    assign grant_oh  = CORES'(1) << grant_q;
    assign ptr_d     = (grant_q == GW'(CORES - 1)) ? '0 : grant_q + 1'b1;

    // Completion may coincide with the strobe acknowledge.
    assign complete = (biu_ack_i | biu_err_i) &&
                      ((state_q == WAIT) || (state_q == ISSUE && biu_stb_ack_i));

    peripheral_mpram_rr_arbiter #(
        .N  (CORES),
        .IW (GW)
    ) u_rr (
        .req_i       (req_stb_i),
        .ptr_i       (ptr_q),
        .mask_i      (elig_mask),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    // One-hot mux of the winning requester's attributes.
    always_comb begin
        sel_adri = '0;
        sel_size = '0;
        sel_type = '0;
        sel_prot = '0;
        sel_lock = 1'b0;
        sel_we   = 1'b0;
        sel_d    = '0;
        for (int k = 0; k < CORES; k++) begin
            if (pick_oh[k]) begin
                sel_adri = req_adri_i[k*PLEN +: PLEN];
                sel_size = req_size_i[k*SIZE_W +: SIZE_W];
                sel_type = req_type_i[k*TYPE_W +: TYPE_W];
                sel_prot = req_prot_i[k*PROT_W +: PROT_W];
                sel_lock = req_lock_i[k];
                sel_we   = req_we_i[k];
                sel_d    = req_d_i[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= IDLE;
            ptr_q              <= '0;
            grant_q            <= '0;
            lock_owner_q       <= '0;
            lock_owner_valid_q <= 1'b0;
            biu_stb_q          <= 1'b0;
            biu_adri_q         <= '0;
            biu_size_q         <= '0;
            biu_type_q         <= '0;
            biu_prot_q         <= '0;
            biu_lock_q         <= 1'b0;
            biu_we_q           <= 1'b0;
            biu_d_q            <= '0;
            req_stb_ack_q      <= '0;
            req_ack_q          <= '0;
            req_err_q          <= '0;
            req_q_q            <= '0;
        end else begin
            req_stb_ack_q <= '0;
            req_ack_q     <= '0;
            req_err_q     <= '0;

            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        biu_adri_q <= sel_adri;
                        biu_size_q <= sel_size;
                        biu_type_q <= sel_type;
                        biu_prot_q <= sel_prot;
                        biu_lock_q <= sel_lock;
                        biu_we_q   <= sel_we;
                        biu_d_q    <= sel_d;
                        grant_q    <= pick_idx;
                        biu_stb_q  <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (biu_stb_ack_i) begin
                        req_stb_ack_q <= grant_oh;
                        biu_stb_q     <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                end
                default: state_q <= IDLE;
            endcase

            // Later assignments override the ISSUE->WAIT move when the
            // transfer also completes this cycle.
            if (complete) begin
                for (int k = 0; k < CORES; k++) begin
                    if (grant_q == GW'(k)) begin
                        req_q_q[k*XLEN +: XLEN] <= biu_q_i;
                    end
                end
                req_ack_q          <= grant_oh & {CORES{biu_ack_i}};
                req_err_q          <= grant_oh & {CORES{biu_err_i}};
                ptr_q              <= ptr_d;
                lock_owner_valid_q <= biu_lock_q;
                lock_owner_q       <= grant_q;
                state_q            <= IDLE;
            end
        end
    end

    assign req_stb_ack_o = req_stb_ack_q;
    assign req_ack_o     = req_ack_q;
    assign req_err_o     = req_err_q;
    assign req_q_o       = req_q_q;
    assign biu_stb_o     = biu_stb_q;
    assign biu_adri_o    = biu_adri_q;
    assign biu_size_o    = biu_size_q;
    assign biu_type_o    = biu_type_q;
    assign biu_prot_o    = biu_prot_q;
    assign biu_lock_o    = biu_lock_q;
    assign biu_we_o      = biu_we_q;
    assign biu_d_o       = biu_d_q;
    assign grant_o       = grant_q;

endmodule

// File: tb/tb_peripheral_mpram_arbiter_tl.sv
// ----------------------------------------------------------------------------
// tb_peripheral_mpram_arbiter_tl
// Directed bench for the MPRAM round-robin arbiter (CORES=4, 64-bit).
// ----------------------------------------------------------------------------
module tb_peripheral_mpram_arbiter_tl;

    localparam int XLEN  = 64;
    localparam int PLEN  = 64;
    localparam int CORES = 4;

    logic                   clk;
    logic                   rst;
    logic [CORES-1:0]       req_stb_i;
    logic [CORES-1:0]       req_stb_ack_o;
    logic [CORES*PLEN-1:0]  req_adri_i;
    logic [CORES*3-1:0]     req_size_i;
    logic [CORES*3-1:0]     req_type_i;
    logic [CORES*3-1:0]     req_prot_i;
    logic [CORES-1:0]       req_lock_i;
    logic [CORES-1:0]       req_we_i;
    logic [CORES*XLEN-1:0]  req_d_i;
    logic [CORES*XLEN-1:0]  req_q_o;
    logic [CORES-1:0]       req_ack_o;
    logic [CORES-1:0]       req_err_o;
    logic                   biu_stb_o;
    logic                   biu_stb_ack_i;
    logic [PLEN-1:0]        biu_adri_o;
    logic [2:0]             biu_size_o;
    logic [2:0]             biu_type_o;
    logic [2:0]             biu_prot_o;
    logic                   biu_lock_o;
    logic                   biu_we_o;
    logic [XLEN-1:0]        biu_d_o;
    logic [XLEN-1:0]        biu_q_i;
    logic                   biu_ack_i;
    logic                   biu_err_i;
    logic [1:0]             grant_o;

    // Requester-side stimulus state
    logic [3:0]             stb_r;
    logic [3:0]             lock_r;
    logic [3:0]             we_r;
    logic [PLEN-1:0]        adr_r  [CORES];
    logic [XLEN-1:0]        dat_r  [CORES];
    logic [2:0]             size_r [CORES];
    logic [2:0]             type_r [CORES];
    logic [2:0]             prot_r [CORES];

    // Expected read-data per requester slice
    logic [XLEN-1:0]        exp_q  [CORES];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  stb;
        logic        sack;
        logic        ack;
        logic [63:0] q;
        logic        e_bstb;
        logic [3:0]  e_sack;
        logic [3:0]  e_ack;
        logic [1:0]  e_grant;
    } vec_t;

    vec_t vecs [8];

    peripheral_mpram_arbiter_tl #(
        .XLEN  (XLEN),
        .PLEN  (PLEN),
        .CORES (CORES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_stb_i     (req_stb_i),
        .req_stb_ack_o (req_stb_ack_o),
        .req_adri_i    (req_adri_i),
        .req_size_i    (req_size_i),
        .req_type_i    (req_type_i),
        .req_prot_i    (req_prot_i),
        .req_lock_i    (req_lock_i),
        .req_we_i      (req_we_i),
        .req_d_i       (req_d_i),
        .req_q_o       (req_q_o),
        .req_ack_o     (req_ack_o),
        .req_err_o     (req_err_o),
        .biu_stb_o     (biu_stb_o),
        .biu_stb_ack_i (biu_stb_ack_i),
        .biu_adri_o    (biu_adri_o),
        .biu_size_o    (biu_size_o),
        .biu_type_o    (biu_type_o),
        .biu_prot_o    (biu_prot_o),
        .biu_lock_o    (biu_lock_o),
        .biu_we_o      (biu_we_o),
        .biu_d_o       (biu_d_o),
        .biu_q_i       (biu_q_i),
        .biu_ack_i     (biu_ack_i),
        .biu_err_i     (biu_err_i),
        .grant_o       (grant_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-requester stimulus onto the flat buses
    always_comb begin
        req_stb_i  = stb_r;
        req_lock_i = lock_r;
        req_we_i   = we_r;
        req_adri_i = '0;
        req_d_i    = '0;
        req_size_i = '0;
        req_type_i = '0;
        req_prot_i = '0;
        for (int k = 0; k < CORES; k++) begin
            req_adri_i[k*PLEN +: PLEN] = adr_r[k];
            req_d_i[k*XLEN +: XLEN]    = dat_r[k];
            req_size_i[k*3 +: 3]       = size_r[k];
            req_type_i[k*3 +: 3]       = type_r[k];
            req_prot_i[k*3 +: 3]       = prot_r[k];
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rdata(input string name);
        for (int j = 0; j < CORES; j++) begin
            check(name, req_q_o[j*XLEN +: XLEN], exp_q[j]);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_biu_stb"}, 64'(biu_stb_o), 64'd0);
        check({name, "_grant"}, 64'(grant_o), 64'd0);
        check({name, "_biu_adri"}, biu_adri_o, 64'd0);
        check({name, "_biu_d"}, biu_d_o, 64'd0);
        check({name, "_biu_attr"}, 64'({biu_size_o, biu_type_o, biu_prot_o, biu_lock_o, biu_we_o}), 64'd0);
        check({name, "_req_pulses"}, 64'({req_stb_ack_o, req_ack_o, req_err_o}), 64'd0);
        check({name, "_req_q"}, 64'(req_q_o != '0), 64'd0);
    endtask

    // Slave driver for one transfer of requester k. Entered in any cycle
    // before biu_stb_o rises; returns in the cycle the completion pulse is
    // visible (arbiter back in IDLE), so the caller can change stimulus
    // before the next arbitration edge.
    task automatic serve(input int k, input logic [63:0] q, input logic err, input logic same);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << k;
        n  = 0;
        while (!biu_stb_o && n < 20) begin
            tick();
            n++;
        end
        check("stb_rise", 64'(biu_stb_o), 64'd1);
        check("grant", 64'(grant_o), 64'(k));
        check("biu_adri", biu_adri_o, adr_r[k]);
        check("biu_d", biu_d_o, dat_r[k]);
        check("biu_we", 64'(biu_we_o), 64'(we_r[k]));
        check("biu_lock", 64'(biu_lock_o), 64'(lock_r[k]));
        check("biu_attr", 64'({biu_size_o, biu_type_o, biu_prot_o}),
              64'({size_r[k], type_r[k], prot_r[k]}));
        biu_stb_ack_i = 1'b1;
        if (same) begin
            biu_ack_i = !err;
            biu_err_i = err;
            biu_q_i   = q;
        end
        tick();
        biu_stb_ack_i = 1'b0;
        check("stb_ack", 64'(req_stb_ack_o), 64'(oh));
        check("biu_stb_drop", 64'(biu_stb_o), 64'd0);
        if (!same) begin
            check("early_resp", 64'(req_ack_o | req_err_o), 64'd0);
            biu_ack_i = !err;
            biu_err_i = err;
            biu_q_i   = q;
            tick();
            check("stb_ack_once", 64'(req_stb_ack_o), 64'd0);
        end
        biu_ack_i = 1'b0;
        biu_err_i = 1'b0;
        biu_q_i   = {$urandom, $urandom};
        check("ack", 64'(req_ack_o), err ? 64'd0 : 64'(oh));
        check("err", 64'(req_err_o), err ? 64'(oh) : 64'd0);
        exp_q[k] = q;
        check_rdata("rdata");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b0;
        stb_r         = '0;
        lock_r        = '0;
        we_r          = '0;
        biu_stb_ack_i = 1'b0;
        biu_ack_i     = 1'b0;
        biu_err_i     = 1'b0;
        biu_q_i       = '0;
        for (int k = 0; k < CORES; k++) begin
            adr_r[k]  = 64'h1000 + 64'(k * 16);
            dat_r[k]  = 64'hA000 + 64'(k);
            size_r[k] = 3'(k);
            type_r[k] = 3'(k + 1);
            prot_r[k] = 3'(k + 2);
            exp_q[k]  = '0;
        end

        // Single requester 2: write 0x100 / 0xDEAD, slave stb_ack in cycle 3,
        // ack in cycle 5. Row n = inputs driven in cycle n and the outputs
        // expected in that same cycle.
        vecs[0] = '{4'b0100, 1'b0, 1'b0, 64'h0, 1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[1] = '{4'b0100, 1'b0, 1'b0, 64'h0, 1'b1, 4'b0000, 4'b0000, 2'd2};
        vecs[2] = '{4'b0100, 1'b0, 1'b0, 64'h0, 1'b1, 4'b0000, 4'b0000, 2'd2};
        vecs[3] = '{4'b0100, 1'b1, 1'b0, 64'h0, 1'b1, 4'b0000, 4'b0000, 2'd2};
        vecs[4] = '{4'b0000, 1'b0, 1'b0, 64'h0, 1'b0, 4'b0100, 4'b0000, 2'd2};
        vecs[5] = '{4'b0000, 1'b0, 1'b1, 64'hCAFE_0002, 1'b0, 4'b0000, 4'b0000, 2'd2};
        vecs[6] = '{4'b0000, 1'b0, 1'b0, 64'h0, 1'b0, 4'b0000, 4'b0100, 2'd2};
        vecs[7] = '{4'b0000, 1'b0, 1'b0, 64'h0, 1'b0, 4'b0000, 4'b0000, 2'd2};

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;

        adr_r[2] = 64'h100;
        dat_r[2] = 64'hDEAD;
        we_r     = 4'b0100;
        for (int r = 0; r < 8; r++) begin
            stb_r         = vecs[r].stb;
            biu_stb_ack_i = vecs[r].sack;
            biu_ack_i     = vecs[r].ack;
            biu_q_i       = vecs[r].q;
            check($sformatf("t1_biu_stb_c%0d", r), 64'(biu_stb_o), 64'(vecs[r].e_bstb));
            check($sformatf("t1_stb_ack_c%0d", r), 64'(req_stb_ack_o), 64'(vecs[r].e_sack));
            check($sformatf("t1_ack_c%0d", r), 64'(req_ack_o | req_err_o), 64'(vecs[r].e_ack));
            check($sformatf("t1_grant_c%0d", r), 64'(grant_o), 64'(vecs[r].e_grant));
            if (vecs[r].e_bstb) begin
                check("t1_adri", biu_adri_o, 64'h100);
                check("t1_wdata", biu_d_o, 64'hDEAD);
                check("t1_we", 64'(biu_we_o), 64'd1);
            end
            tick();
        end
        biu_stb_ack_i = 1'b0;
        biu_ack_i     = 1'b0;
        exp_q[2]      = 64'hCAFE_0002;
        check_rdata("t1_rdata");

        // Reset while requester 0 waits for its response
        adr_r[0] = 64'h200;
        we_r     = 4'b0000;
        stb_r    = 4'b0001;
        for (int n = 0; n < 20 && !biu_stb_o; n++) tick();
        check("rw_stb", 64'(biu_stb_o), 64'd1);
        check("rw_grant", 64'(grant_o), 64'd0);
        biu_stb_ack_i = 1'b1;
        tick();
        biu_stb_ack_i = 1'b0;
        stb_r         = 4'b0000;
        check("rw_stb_ack", 64'(req_stb_ack_o), 64'b0001);
        rst       = 1'b0;
        biu_ack_i = 1'b1;
        biu_q_i   = 64'h5555;
        tick();
        for (int k = 0; k < CORES; k++) exp_q[k] = '0;
        check_all_zero("rw_reset");
        rst       = 1'b1;
        biu_ack_i = 1'b0;
        tick();
        check("rw_no_ack", 64'(req_ack_o | req_err_o), 64'd0);
        check("rw_idle", 64'(biu_stb_o), 64'd0);

        // Fairness: everyone strobes, grants rotate from index 0
        adr_r[0] = 64'h1000;
        dat_r[2] = 64'hA002;
        we_r     = 4'b1010;
        stb_r    = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            serve(i % 4, 64'hF000 + 64'(i), 1'b0, 1'b0);
        end

        // Requester 2 read with strobe-ack and ack in the same cycle
        stb_r    = 4'b0100;
        we_r     = 4'b0000;
        adr_r[2] = 64'h80;
        serve(2, 64'h1234, 1'b0, 1'b1);

        // Requester 3 read at 0x40 answered with an error
        stb_r    = 4'b1000;
        adr_r[3] = 64'h40;
        serve(3, 64'hBAD0, 1'b1, 1'b0);

        // Lock: requester 1 locked read then unlocked read, 0 and 3 strobing
        stb_r  = 4'b1011;
        lock_r = 4'b0010;
        serve(0, 64'h0C00, 1'b0, 1'b0);
        serve(1, 64'h0C01, 1'b0, 1'b0);
        lock_r = 4'b0000;
        serve(1, 64'h0C02, 1'b0, 1'b0);
        stb_r = 4'b1001;
        serve(3, 64'h0C03, 1'b0, 1'b0);
        serve(0, 64'h0C04, 1'b0, 1'b0);

        // Slave responses while idle are ignored
        stb_r     = 4'b0000;
        biu_ack_i = 1'b1;
        biu_err_i = 1'b1;
        biu_q_i   = 64'hFFFF;
        tick();
        biu_ack_i = 1'b0;
        biu_err_i = 1'b0;
        tick();
        check("idle_quiet_stb", 64'(biu_stb_o), 64'd0);
        check("idle_quiet_resp", 64'(req_ack_o | req_err_o), 64'd0);
        check_rdata("idle_quiet_rdata");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
